// File: rtl/core_fetch_pkg.sv
// rtl/core_fetch_pkg.sv - shared constants and entry type for the instruction fetch front end
package core_fetch_pkg;

    // Instruction presented to the core while the prefetch queue is empty (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - synchronous FIFO with flush, occupancy count and combinational head
//
// Ports:
//   clk        core clock
//   reset      synchronous active-high reset, empties the FIFO
//   flush      synchronous clear; overrides push and pop in the same cycle
//   push       write push_data at the tail (dropped only when full with no pop)
//   push_data  entry to write
//   pop        remove the head entry (ignored when empty)
//   count      number of stored entries, 0..DEPTH
//   head       oldest entry; undefined contents when count == 0
module prefetch_fifo
    import core_fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output entry_t                       head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt_q;
    logic            pop_ok;
    logic            push_ok;
    logic            clear;

    assign clear   = reset | flush;
    assign pop_ok  = pop & (cnt_q != '0);
    // A push into a full FIFO is fine when the head leaves in the same cycle:
    // wr_ptr == rd_ptr then, and the freed slot becomes the new tail.
    assign push_ok = push & ((cnt_q != FULL_CNT) | pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign count = cnt_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - sequential instruction prefetcher with in-order response queue and redirect flush
//
// Ports:
//   clk          core clock
//   reset        synchronous active-high reset
//   redirect     taken branch/jump from X stage
//   redirect_pc  new fetch address
//   fetch_ready  core accepts the head instruction this cycle
//   instr_f      head instruction, NOP when empty
//   fetch_pc     PC of head instruction, next prefetch PC when empty
//   instr_valid  head entry valid
//   fetch_stall  queue empty, core must hold F
//   imem_req     request valid
//   imem_addr    request word address
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  in-order response valid
//   imem_rdata   response instruction
module instr_prefetch_buffer
    import core_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_ready,
    output logic [31:0] instr_f,
    output logic [31:0] fetch_pc,
    output logic        instr_valid,
    output logic        fetch_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [31:0]   pf_pc;
    logic [CW-1:0] q_count;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   credit_used;
    fetch_entry_t  q_head;
    fetch_entry_t  q_push_data;
    logic [31:0]   tag_head;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          q_push;
    logic          q_pop;

    // Every queue slot is reserved at request time, so a response can always be written.
    assign credit_used = {1'b0, q_count} + {1'b0, out_cnt};
    assign imem_req    = ~reset & ~redirect & (credit_used < CREDITS);
    assign imem_addr   = pf_pc;
    assign req_fire    = imem_req & imem_gnt;

    // Responses only count against requests we are still tracking; anything
    // from before a reset is outside that set.
    assign rsp_fire    = imem_rvalid & (out_cnt != '0);
    assign rsp_keep    = rsp_fire & (drop_cnt == '0) & ~redirect;

    assign q_push      = rsp_keep;
    assign q_pop       = instr_valid & fetch_ready & ~redirect;
    assign q_push_data = '{pc: tag_head, instr: imem_rdata};

    prefetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_instr_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .count     (q_count),
        .head      (q_head)
    );

    // PC tags of granted requests; never flushed on redirect because stale
    // responses still arrive and must pop their tags in order.
    prefetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (logic [31:0])
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pf_pc),
        .pop       (rsp_fire),
        .count     (out_cnt),
        .head      (tag_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_pc    <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect) begin
            // No grant can happen this cycle, so whatever remains in flight
            // after this edge is stale.
            pf_pc    <= redirect_pc;
            drop_cnt <= out_cnt - CW'(rsp_fire);
        end else begin
            if (req_fire) begin
                pf_pc <= pf_pc + 32'd4;
            end
            if (rsp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    assign instr_valid = (q_count != '0);
    assign fetch_stall = ~instr_valid;
    assign instr_f     = instr_valid ? q_head.instr : NOP_INSTR;
    assign fetch_pc    = instr_valid ? q_head.pc    : pf_pc;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - self-checking bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;
    import core_fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, redirect, fetch_ready, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic [31:0] instr_f, fetch_pc, imem_addr;
    logic        instr_valid, fetch_stall, imem_req;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_ready (fetch_ready),
        .instr_f     (instr_f),
        .fetch_pc    (fetch_pc),
        .instr_valid (instr_valid),
        .fetch_stall (fetch_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
    );

    typedef struct {
        logic [31:0] pc;
        logic        stale;
    } out_rec_t;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        valid;
        logic [31:0] fpc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    // Reference: buffered instructions, requests in flight (the memory serves
    // them in order), and the next fetch address.
    fetch_entry_t m_q[$];
    out_rec_t     m_out[$];
    logic [31:0]  m_pf_pc = RESET_PC;
    bit           rand_data = 1'b0;

    logic        s_valid, s_stall, s_req;
    logic [31:0] s_instr, s_fpc, s_addr;
    logic        e_valid, e_req;
    logic [31:0] e_instr, e_fpc, e_addr;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic sample();
        s_valid = instr_valid;
        s_stall = fetch_stall;
        s_instr = instr_f;
        s_fpc   = fetch_pc;
        s_req   = imem_req;
        s_addr  = imem_addr;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset = 1'b1; redirect = 1'b0; redirect_pc = '0; fetch_ready = 1'b1;
            imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
            #1 sample();
            @(posedge clk);
        end
        m_q.delete();
        m_out.delete();
        m_pf_pc = RESET_PC;
    endtask

    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy,
                        input logic g, input logic rv);
        logic         rv_eff;
        out_rec_t     rec;
        fetch_entry_t gone;
        @(negedge clk);
        rv_eff = rv && (m_out.size() != 0);
        reset = 1'b0; redirect = rd; redirect_pc = rpc; fetch_ready = rdy;
        imem_gnt = g; imem_rvalid = rv_eff; imem_rdata = '0;
        if (rv_eff) imem_rdata = rand_data ? $urandom : (m_out[0].pc | 32'hA000_0000);
        e_valid = (m_q.size() != 0);
        e_instr = e_valid ? m_q[0].instr : NOP_INSTR;
        e_fpc   = e_valid ? m_q[0].pc : m_pf_pc;
        e_req   = !rd && ((m_q.size() + m_out.size()) < DEPTH);
        e_addr  = m_pf_pc;
        #1 sample();
        if (rv_eff) begin
            rec = m_out.pop_front();
            if (!rec.stale && !rd) m_q.push_back('{pc: rec.pc, instr: imem_rdata});
        end
        if (rd) begin
            m_q.delete();
            for (int i = 0; i < m_out.size(); i++) m_out[i].stale = 1'b1;
            m_pf_pc = rpc;
        end else begin
            if (e_valid && rdy) gone = m_q.pop_front();
            if (e_req && g) begin
                m_out.push_back('{pc: m_pf_pc, stale: 1'b0});
                m_pf_pc = m_pf_pc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"}, 32'(s_valid), 32'(e_valid));
        chk({tag, ".stall"}, 32'(s_stall), 32'(!e_valid));
        chk({tag, ".instr"}, s_instr, e_instr);
        chk({tag, ".fpc"},   s_fpc,   e_fpc);
        chk({tag, ".req"},   32'(s_req), 32'(e_req));
        chk({tag, ".addr"},  s_addr,  e_addr);
    endtask

    function automatic vec_t v(input logic rd, input logic [31:0] rpc, input logic rdy,
                               input logic valid, input logic [31:0] fpc,
                               input logic req, input logic [31:0] addr);
        vec_t r;
        r.rd = rd; r.rpc = rpc; r.rdy = rdy; r.valid = valid;
        r.fpc = fpc; r.req = req; r.addr = addr;
        return r;
    endfunction

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; fetch_ready = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // Always-granting memory answering one cycle after grant.
        vecs[0]  = v(0, 32'h0,        1, 0, 32'h0000_0000, 1, 32'h0000_0000);
        vecs[1]  = v(0, 32'h0,        1, 0, 32'h0000_0004, 1, 32'h0000_0004);
        vecs[2]  = v(0, 32'h0,        1, 1, 32'h0000_0000, 1, 32'h0000_0008);
        vecs[3]  = v(0, 32'h0,        1, 1, 32'h0000_0004, 1, 32'h0000_000C);
        vecs[4]  = v(0, 32'h0,        1, 1, 32'h0000_0008, 1, 32'h0000_0010);
        vecs[5]  = v(0, 32'h0,        1, 1, 32'h0000_000C, 1, 32'h0000_0014);
        vecs[6]  = v(0, 32'h0,        0, 1, 32'h0000_0010, 1, 32'h0000_0018);
        vecs[7]  = v(0, 32'h0,        0, 1, 32'h0000_0010, 1, 32'h0000_001C);
        vecs[8]  = v(0, 32'h0,        0, 1, 32'h0000_0010, 0, 32'h0000_0020);
        vecs[9]  = v(0, 32'h0,        0, 1, 32'h0000_0010, 0, 32'h0000_0020);
        vecs[10] = v(0, 32'h0,        1, 1, 32'h0000_0010, 0, 32'h0000_0020);
        vecs[11] = v(0, 32'h0,        0, 1, 32'h0000_0014, 1, 32'h0000_0020);
        vecs[12] = v(0, 32'h0,        0, 1, 32'h0000_0014, 0, 32'h0000_0024);
        vecs[13] = v(0, 32'h0,        0, 1, 32'h0000_0014, 0, 32'h0000_0024);
        vecs[14] = v(1, 32'h100,      1, 1, 32'h0000_0014, 0, 32'h0000_0024);
        vecs[15] = v(0, 32'h0,        1, 0, 32'h0000_0100, 1, 32'h0000_0100);
        vecs[16] = v(0, 32'h0,        1, 0, 32'h0000_0104, 1, 32'h0000_0104);
        vecs[17] = v(0, 32'h0,        1, 1, 32'h0000_0100, 1, 32'h0000_0108);
        vecs[18] = v(0, 32'h0,        1, 1, 32'h0000_0104, 1, 32'h0000_010C);
        vecs[19] = v(1, 32'hFFFF_FFF8, 1, 1, 32'h0000_0108, 0, 32'h0000_0110);
        vecs[20] = v(0, 32'h0,        1, 0, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8);
        vecs[21] = v(0, 32'h0,        1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        vecs[22] = v(0, 32'h0,        1, 1, 32'hFFFF_FFF8, 1, 32'h0000_0000);
        vecs[23] = v(0, 32'h0,        1, 1, 32'hFFFF_FFFC, 1, 32'h0000_0004);
        vecs[24] = v(0, 32'h0,        1, 1, 32'h0000_0000, 1, 32'h0000_0008);

        // Reset state.
        do_reset(2);
        chk("rst.valid", 32'(s_valid), 32'd0);
        chk("rst.stall", 32'(s_stall), 32'd1);
        chk("rst.instr", s_instr, 32'h0000_0013);
        chk("rst.fpc",   s_fpc,   RESET_PC);
        chk("rst.req",   32'(s_req), 32'd0);

        // Directed table: streaming, full-queue stall, redirects, pc wrap.
        rand_data = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(vecs[i].rd, vecs[i].rpc, vecs[i].rdy, 1'b1, 1'b1);
            chk($sformatf("vec%0d.valid", i), 32'(s_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d.stall", i), 32'(s_stall), 32'(!vecs[i].valid));
            chk($sformatf("vec%0d.fpc", i),   s_fpc, vecs[i].fpc);
            chk($sformatf("vec%0d.instr", i), s_instr,
                vecs[i].valid ? (vecs[i].fpc | 32'hA000_0000) : 32'h0000_0013);
            chk($sformatf("vec%0d.req", i),   32'(s_req), 32'(vecs[i].req));
            chk($sformatf("vec%0d.addr", i),  s_addr, vecs[i].addr);
        end

        // Two requests (0x8, 0xC) in flight when a redirect to 0x100 arrives.
        rand_data = 1'b1;
        do_reset(1);
        step(0, 0, 1, 1, 0); cmp_model("rd2.c0");
        step(0, 0, 1, 1, 1); cmp_model("rd2.c1");
        step(0, 0, 1, 1, 1); cmp_model("rd2.c2");
        step(0, 0, 1, 1, 0); cmp_model("rd2.c3");
        step(1, 32'h100, 1, 1, 0); cmp_model("rd2.c4");
        chk("rd2.redirect_req", 32'(s_req), 32'd0);
        for (int i = 5; i < 8; i++) begin
            step(0, 0, 1, 1, 1); cmp_model($sformatf("rd2.c%0d", i));
            chk($sformatf("rd2.stale_hidden%0d", i), 32'(s_valid), 32'd0);
        end
        step(0, 0, 1, 1, 1); cmp_model("rd2.c8");
        chk("rd2.first_valid", 32'(s_valid), 32'd1);
        chk("rd2.first_pc", s_fpc, 32'h0000_0100);

        // Fill the queue, then reset for one cycle.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 1); cmp_model($sformatf("full.c%0d", i));
        end
        chk("full.req_low", 32'(s_req), 32'd0);
        chk("full.valid", 32'(s_valid), 32'd1);
        do_reset(1);
        chk("rstmid.req", 32'(s_req), 32'd0);
        step(0, 0, 1, 1, 0); cmp_model("rstmid.after");
        chk("rstmid.valid", 32'(s_valid), 32'd0);
        chk("rstmid.stall", 32'(s_stall), 32'd1);
        chk("rstmid.instr", s_instr, 32'h0000_0013);
        chk("rstmid.fpc",   s_fpc, RESET_PC);
        chk("rstmid.req1",  32'(s_req), 32'd1);
        chk("rstmid.addr",  s_addr, RESET_PC);

        // Randomised traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1);
            step($urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) == 1);
            cmp_model("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
